ysyx_22040759_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22040759_mem_arbiter
// PURPOSE
//  Shares one 64-bit memory port between the IF stage (instruction read) and the
//  LSU (data read/write). One transaction in flight; 4-state FSM sequences command,
//  grant and response. Sits between IF/MEM stages and the unified SRAM/bus bridge.
//  IF responses are cancelled on a branch flush so stale instructions never return.
// PARAMETERS
//  STARVE_MAX  4   consecutive LSU wins over a waiting IF before IF is forced to win
//  CNT_W       3   width of starvation counter; must hold STARVE_MAX
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst_n       in   1   synchronous reset, active low
//  if_req      in   1   IF read request (level; held until if_gnt)
//  if_addr     in   64  IF fetch address; bit[2] selects 32-bit half
//  if_flush    in   1   branch flush: cancel pending/in-flight IF access
//  if_gnt      out  1   1-cycle pulse: IF command accepted
//  if_rvalid   out  1   1-cycle pulse: if_rdata valid
//  if_rdata    out  32  fetched instruction
//  ls_req      in   1   LSU request (level; held until ls_gnt)
//  ls_we       in   1   1 = write, 0 = read
//  ls_addr     in   64  LSU address, 8-byte aligned beat
//  ls_wdata    in   64  write data
//  ls_wstrb    in   8   byte enables for write
//  ls_gnt      out  1   1-cycle pulse: LSU command accepted
//  ls_rvalid   out  1   1-cycle pulse: read data valid / write acknowledged
//  ls_rdata    out  64  read data (0 on write ack)
//  mem_req     out  1   command valid to memory; held until mem_gnt
//  mem_we      out  1   command write flag (0 for IF)
//  mem_addr    out  64  command address
//  mem_wdata   out  64  write data
//  mem_wstrb   out  8   byte enables (0 for reads)
//  mem_gnt     in   1   memory accepted command this cycle
//  mem_rvalid  in   1   memory response this cycle
//  mem_rdata   in   64  memory response data
//  busy        out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, starve_cnt=0, drop=0, owner=IF; all
//    outputs 0; mem_rvalid while IDLE is ignored (kills responses from pre-reset ops).
//  - States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  - IDLE: eligible IF = if_req & ~if_flush. Winner picked combinationally, gnt pulsed
//    same cycle, command (we/addr/wdata/wstrb/owner) registered; next=REQ.
//    Neither eligible: stay IDLE, no gnt.
//  - Priority: LSU wins ties (older instruction, avoids deadlock), except as in CONFIG.
//  - REQ: mem_req=1 with registered command; on mem_gnt -> WAIT. mem_rvalid in same
//    cycle as mem_gnt is legal: treat as response, go directly to RESP.
//  - WAIT: on mem_rvalid capture mem_rdata -> RESP.
//  - RESP: pulse owner rvalid for exactly 1 cycle (unless drop); IF data =
//    addr[2] ? rdata[63:32] : rdata[31:0]; LSU write -> ls_rdata=0. next=IDLE.
//    New arbitration starts in the following cycle (no back-to-back overlap).
//  - Min latency req->rvalid: 3 cycles (req@T gnt@T, mem_req@T+1 w/ gnt+rvalid, rvalid@T+2).
//  - Flush: if_flush in REQ/WAIT/RESP with owner=IF sets drop; memory op still completes,
//    if_rvalid suppressed; drop clears on entering IDLE. Flush has no effect on LSU ops.
//  - if_gnt and ls_gnt never both 1; if_rvalid and ls_rvalid never both 1.
//  - No timeout: memory must eventually respond.
// CONFIGURATION
//  YSYX_22040759_ARB_STARVE_EN defined: starve_cnt increments (saturating) when LSU wins
//    while IF is eligible; resets to 0 when IF wins. When starve_cnt==STARVE_MAX and IF
//    eligible, IF wins even if ls_req=1.
//  Not defined: starve_cnt absent; LSU always wins ties (strict priority).
// TESTING
//  1 IF only: if_req, if_addr=0x8000_0004, mem returns 0xDEAD_BEEF_0000_0013 on next
//    cycle -> if_gnt@T, if_rvalid@T+2 with if_rdata=0xDEADBEEF.
//  2 Tie: if_req & ls_req(read 0x8000_1000) at T -> ls_gnt@T, ls_rvalid first, if_gnt
//    at first IDLE after RESP; mem_we=0, mem_wstrb=0 for both.
//  3 Flush: IF granted, mem_rvalid delayed 5 cycles, if_flush pulse in WAIT ->
//    no if_rvalid, busy drops after RESP, next ls_req served normally.
//  4 Write: ls_we=1, ls_wstrb=0x0F, ls_wdata=0x1122334455667788 -> mem fields match,
//    ls_rvalid with ls_rdata=0.
//  5 Starvation (STARVE_EN, STARVE_MAX=4): ls_req and if_req held high -> 4 LSU grants
//    then 1 IF grant, repeating; without macro: LSU granted every time.
//  6 Reset mid-op: rst_n=0 in WAIT, mem_rvalid after release -> no rvalid, busy=0,
//    all outputs 0.

Source files
------------

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// ysyx_22040759_mem_arbiter_if: IF/LSU request and memory command/response bundle for the arbiter
interface ysyx_22040759_mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter: shares one 64-bit memory port between IF fetch and LSU, one op in flight
// YSYX_22040759_ARB_STARVE_EN enables the IF anti-starvation counter (otherwise strict LSU priority)
module ysyx_22040759_mem_arbiter
`ifdef YSYX_22040759_ARB_STARVE_EN
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
)
`endif
(
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_22040759_mem_arbiter_if.slave   bus,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic        owner_ls, we_q, drop, if_elig, pick_if, if_resp;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  wstrb_q;
  assign if_elig = bus.if_req & ~bus.if_flush;
`ifdef YSYX_22040759_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt;
  assign pick_if = if_elig & (~bus.ls_req | starve_cnt == CNT_W'(STARVE_MAX));
  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt <= '0;
    else if (bus.if_gnt) starve_cnt <= '0;
    else if (bus.ls_gnt & if_elig & starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign pick_if = if_elig & ~bus.ls_req;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // a response arriving with the command grant skips WAIT
  always_comb begin
    state_nx = state == IDLE ? ((if_elig | bus.ls_req) ? REQ : IDLE)
             : state == REQ  ? (!bus.mem_gnt ? REQ : bus.mem_rvalid ? RESP : WAIT)
             : state == WAIT ? (bus.mem_rvalid ? RESP : WAIT)
             : IDLE;
  end
  always_comb begin
    busy          = state != IDLE;
    bus.if_gnt    = state == IDLE & pick_if;
    bus.ls_gnt    = state == IDLE & bus.ls_req & ~pick_if;
    bus.mem_req   = state == REQ;
    bus.mem_we    = state == REQ & we_q;
    bus.mem_addr  = state == REQ ? addr_q : '0;
    bus.mem_wdata = state == REQ ? wdata_q : '0;
    bus.mem_wstrb = state == REQ ? wstrb_q : '0;
    if_resp       = state == RESP & ~owner_ls & ~drop & ~bus.if_flush;
    bus.if_rvalid = if_resp;
    bus.if_rdata  = if_resp ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]) : '0;
    bus.ls_rvalid = state == RESP & owner_ls;
    bus.ls_rdata  = state == RESP & owner_ls & ~we_q ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      drop     <= 1'b0;
    end else begin
      if (bus.if_gnt | bus.ls_gnt) begin
        owner_ls <= bus.ls_gnt;
        we_q     <= bus.ls_gnt & bus.ls_we;
        addr_q   <= bus.ls_gnt ? bus.ls_addr : bus.if_addr;
        wdata_q  <= bus.ls_gnt & bus.ls_we ? bus.ls_wdata : '0;
        wstrb_q  <= bus.ls_gnt & bus.ls_we ? bus.ls_wstrb : '0;
      end
      if (((state == REQ & bus.mem_gnt) | state == WAIT) & bus.mem_rvalid) rdata_q <= bus.mem_rdata;
      drop <= (state == REQ | state == WAIT) & (drop | (bus.if_flush & ~owner_ls));
    end
  end
endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// tb_ysyx_22040759_mem_arbiter: directed self-checking bench for the IF/LSU memory arbiter
module tb_ysyx_22040759_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  logic exp_if;
  ysyx_22040759_mem_arbiter_if bus();
  ysyx_22040759_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_wstrb = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_gnts", {bus.if_gnt, bus.ls_gnt}, 0);
    chk("rst_rvalids", {bus.if_rvalid, bus.ls_rvalid}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1;
    tick;
    // 1: IF only, response with grant
    bus.if_req = 1; bus.if_addr = 64'h8000_0004;
    #1;
    chk("t1_if_gnt", bus.if_gnt, 1);
    chk("t1_ls_gnt", bus.ls_gnt, 0);
    tick;
    bus.if_req = 0; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD_BEEF_0000_0013;
    #1;
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 64'h8000_0004);
    chk("t1_mem_we", bus.mem_we, 0);
    chk("t1_mem_wstrb", bus.mem_wstrb, 0);
    chk("t1_busy", busy, 1);
    chk("t1_early_rvalid", bus.if_rvalid, 0);
    tick;
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    chk("t1_if_rvalid", bus.if_rvalid, 1);
    chk("t1_if_rdata", bus.if_rdata, 64'hDEADBEEF);
    chk("t1_ls_rvalid", bus.ls_rvalid, 0);
    tick;
    chk("t1_idle_busy", busy, 0);
    chk("t1_rvalid_pulse", bus.if_rvalid, 0);
    // 2: tie, LSU first
    bus.if_req = 1; bus.if_addr = 64'h8000_0000;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 64'h8000_1000;
    #1;
    chk("t2_ls_gnt", bus.ls_gnt, 1);
    chk("t2_if_gnt", bus.if_gnt, 0);
    tick;
    bus.ls_req = 0; bus.mem_gnt = 1;
    #1;
    chk("t2_mem_addr_ls", bus.mem_addr, 64'h8000_1000);
    chk("t2_mem_we_ls", bus.mem_we, 0);
    chk("t2_mem_wstrb_ls", bus.mem_wstrb, 0);
    chk("t2_if_gnt_req", bus.if_gnt, 0);
    tick;
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick;
    bus.mem_rvalid = 0;
    chk("t2_ls_rvalid", bus.ls_rvalid, 1);
    chk("t2_ls_rdata", bus.ls_rdata, 64'h0123_4567_89AB_CDEF);
    chk("t2_if_rvalid_resp", bus.if_rvalid, 0);
    chk("t2_if_gnt_resp", bus.if_gnt, 0);
    tick;
    chk("t2_if_gnt", bus.if_gnt, 1);
    tick;
    bus.if_req = 0; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("t2_mem_addr_if", bus.mem_addr, 64'h8000_0000);
    chk("t2_mem_we_if", bus.mem_we, 0);
    chk("t2_mem_wstrb_if", bus.mem_wstrb, 0);
    tick;
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    chk("t2_if_rvalid", bus.if_rvalid, 1);
    chk("t2_if_rdata_lo", bus.if_rdata, 64'h3333_4444);
    tick;
    // 3: flush during WAIT
    bus.if_req = 1; bus.if_addr = 64'h8000_0008;
    #1;
    chk("t3_if_gnt", bus.if_gnt, 1);
    tick;
    bus.if_req = 0; bus.mem_gnt = 1;
    tick;
    bus.mem_gnt = 0; bus.if_flush = 1;
    #1;
    chk("t3_busy_wait", busy, 1);
    tick;
    bus.if_flush = 0;
    tick; tick; tick;
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h5555_6666_7777_8888;
    tick;
    bus.mem_rvalid = 0;
    chk("t3_no_if_rvalid", bus.if_rvalid, 0);
    chk("t3_busy_resp", busy, 1);
    tick;
    chk("t3_busy_idle", busy, 0);
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 64'h8000_2000;
    #1;
    chk("t3_ls_gnt", bus.ls_gnt, 1);
    tick;
    bus.ls_req = 0; bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick;
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    chk("t3_ls_rvalid", bus.ls_rvalid, 1);
    chk("t3_ls_rdata", bus.ls_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    tick;
    // 4: LSU write
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 64'h8000_3000;
    bus.ls_wdata = 64'h1122_3344_5566_7788; bus.ls_wstrb = 8'h0F;
    #1;
    chk("t4_ls_gnt", bus.ls_gnt, 1);
    tick;
    bus.ls_req = 0; bus.mem_gnt = 1;
    #1;
    chk("t4_mem_we", bus.mem_we, 1);
    chk("t4_mem_wstrb", bus.mem_wstrb, 8'h0F);
    chk("t4_mem_wdata", bus.mem_wdata, 64'h1122_3344_5566_7788);
    chk("t4_mem_addr", bus.mem_addr, 64'h8000_3000);
    tick;
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    bus.mem_rvalid = 0;
    chk("t4_ls_rvalid", bus.ls_rvalid, 1);
    chk("t4_ls_rdata", bus.ls_rdata, 0);
    tick;
    bus.ls_we = 0; bus.ls_wstrb = 0;
    // 5: both requesters held high
    bus.if_req = 1; bus.if_addr = 64'h8000_0010;
    bus.ls_req = 1; bus.ls_addr = 64'h8000_4000;
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h0;
    for (int i = 0; i < 5; i++) begin
`ifdef YSYX_22040759_ARB_STARVE_EN
      exp_if = (i == 4);
`else
      exp_if = 1'b0;
`endif
      #1;
      chk($sformatf("t5_if_gnt_%0d", i), bus.if_gnt, exp_if);
      chk($sformatf("t5_ls_gnt_%0d", i), bus.ls_gnt, !exp_if);
      tick; tick; tick;
    end
    bus.if_req = 0; bus.ls_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    tick;
    // 6: reset while waiting on memory
    bus.if_req = 1; bus.if_addr = 64'h8000_0020;
    #1;
    chk("t6_if_gnt", bus.if_gnt, 1);
    tick;
    bus.if_req = 0; bus.mem_gnt = 1;
    tick;
    bus.mem_gnt = 0; rst_n = 0;
    tick;
    rst_n = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h9999_9999_9999_9999;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_mem_req_rst", bus.mem_req, 0);
    tick;
    bus.mem_rvalid = 0;
    chk("t6_rvalids", {bus.if_rvalid, bus.ls_rvalid}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mem_req", bus.mem_req, 0);
    chk("t6_if_rdata", bus.if_rdata, 0);
    // flushed IF request is not eligible
    bus.if_req = 1; bus.if_flush = 1;
    #1;
    chk("flush_blocks_gnt", bus.if_gnt, 0);
    tick;
    chk("flush_stays_idle", busy, 0);
    bus.if_req = 0; bus.if_flush = 0;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
